// File: rtl/i2c_slave_if.sv
// Host-side handshake bundle of the I2C target: read-byte request
// and write-byte strobe toward the local host logic.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;

    modport slave (
        input  tx_data,
        output tx_req, rx_data, rx_valid, rw, busy
    );

    modport master (
        output tx_data,
        input  tx_req, rx_data, rx_valid, rw, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled scl/sda, START/STOP detection,
// address match, write bytes to a strobe, read bytes from a request.
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scl,
    inout  wire         sda,
    i2c_slave_if.slave  hst
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA,
        WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start, stop;

    state_t     state;
    logic [7:0] shift;
    logic [2:0] cnt;
    logic       phase;
    logic       drv;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw, busy;

    assign sda = drv ? 1'b0 : 1'bz;

    assign hst.rx_data  = rx_data;
    assign hst.rx_valid = rx_valid;
    assign hst.tx_req   = tx_req;
    assign hst.rw       = rw;
    assign hst.busy     = busy;

    // Flops reset high so an idle bus is seen on reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // scl must be stable high, so a coincident scl edge counts as data.
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            shift    <= 8'h00;
            cnt      <= 3'd0;
            phase    <= 1'b0;
            drv      <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                drv   <= 1'b0;
                cnt   <= 3'd0;
                phase <= 1'b0;
            end else if (start) begin
                state <= ADDR;
                drv   <= 1'b0;
                cnt   <= 3'd0;
                phase <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shift <= {shift[6:0], sda_s};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (shift[6:0] == SLV_ADDR) begin
                                rw    <= sda_s;
                                phase <= 1'b0;
                                state <= ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            drv    <= 1'b1;
                            busy   <= 1'b1;
                            phase  <= 1'b1;
                            tx_req <= rw;
                        end else begin
                            phase <= 1'b0;
                            cnt   <= 3'd0;
                            if (rw) begin
                                shift <= hst.tx_data;
                                drv   <= ~hst.tx_data[7];
                                state <= RD_DATA;
                            end else begin
                                drv   <= 1'b0;
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        shift <= {shift[6:0], sda_s};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data  <= {shift[6:0], sda_s};
                            rx_valid <= 1'b1;
                            phase    <= 1'b0;
                            state    <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            drv   <= 1'b1;
                            phase <= 1'b1;
                        end else begin
                            drv   <= 1'b0;
                            phase <= 1'b0;
                            cnt   <= 3'd0;
                            state <= WR_DATA;
                        end
                    end
                    // MSB is already on the bus; each fall presents the next bit.
                    RD_DATA: if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            drv   <= 1'b0;
                            cnt   <= 3'd0;
                            state <= RD_ACK;
                        end else begin
                            shift <= {shift[6:0], 1'b0};
                            drv   <= ~shift[6];
                            cnt   <= cnt + 3'd1;
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) tx_req <= 1'b1;
                            else state <= WAIT_STOP;
                        end else if (scl_fall) begin
                            shift <= hst.tx_data;
                            drv   <= ~hst.tx_data[7];
                            cnt   <= 3'd0;
                            state <= RD_DATA;
                        end
                    end
                    WAIT_STOP: drv <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
